hd_scoreboard: RTL
==================

Name: hd_scoreboard

Overview:
- Parametrised hazard unit for the rv32i pipeline; replaces the single-slot load-use detector.
- Tracks every in-flight long-latency producer (loads, plus optional external long ops such as mul/div) in a per-register pending-count scoreboard, from ID issue until writeback.
- Stalls the IF/ID consumer on any RAW against a pending register, and stalls on a full scoreboard.
- Generates a multi-cycle front-end flush after an EX-stage redirect; sits beside the IF/ID and ID/EX pipeline registers.

Parameters:
NREGS, 32, architectural registers tracked (x0 never tracked)
MAX_PEND, 4, max outstanding long ops in flight (structural limit)
FLUSH_DEPTH, 2, cycles flush_o stays high per redirect (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_opcode  in  rv32i_opcode  opcode of the IF/ID instruction
id_rs1  in  5  source 1 index
id_rs2  in  5  source 2 index
id_rd  in  5  destination index
id_long_ext  in  1  non-load long-latency op (mul/div)
pipe_freeze  in  1  global memory stall; no instruction leaves ID
wb_valid  in  1  writeback this cycle
wb_long  in  1  writeback belongs to a tracked long op
wb_rd  in  5  writeback destination
ex_redirect  in  1  taken branch / jal / jalr resolved in EX
stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX
flush_o  out  1  squash IF/ID (and fetch) contents
sb_full_o  out  1  outstanding count == MAX_PEND
pend_total_o  out  $clog2(MAX_PEND+1)  outstanding long ops
sb_err_o  out  1  sticky: retire against zero count

Behaviour:
- Reset (async, rst_n=0): all per-register counts 0, total 0, flush counter 0, sb_err_o 0. Outputs: stall_o 0, flush_o 0, sb_full_o 0, pend_total_o 0.
- Source use decode:
  - rs1 used by op_jalr, op_br, op_load, op_store, op_imm, op_reg.
  - rs2 used by op_br, op_store, op_reg only. op_imm does not use rs2.
  - Index 0 is never hazardous.
- long = (id_opcode==op_load) | id_long_ext.
- Retire: ret = wb_valid & wb_long & wb_rd!=0.
- Effective count: eff_cnt[r] = cnt[r] - (ret & wb_rd==r). The regfile writes through, so a same-cycle retire clears the hazard combinationally.
- RAW: raw = id_valid & ((use1 & eff_cnt[rs1]!=0) | (use2 & eff_cnt[rs2]!=0)).
- Structural: struct = id_valid & long & id_rd!=0 & total_eff==MAX_PEND, where total_eff = total - ret.
- stall_o = (raw | struct) & ~flush_o. Combinational; the squashed instruction never stalls.
- Issue: fire = id_valid & ~stall_o & ~flush_o & ~pipe_freeze. iss = fire & long & id_rd!=0.
- Scoreboard update, on the clk edge only:
  - cnt[id_rd] increments on iss; cnt[wb_rd] decrements on ret.
  - Same register issued and retired in one cycle: net unchanged.
  - total updates likewise (+iss, -ret).
  - A producer issued in cycle N is visible to the consumer in cycle N+1 (zero-bubble detection; a back-to-back load-use costs one stall cycle minimum).
- Retire on a zero count: count stays 0, sb_err_o sets and holds until reset.
- pipe_freeze blocks issue but not retire; wb continues to drain.
- Per-register count width is $clog2(MAX_PEND+1). It cannot overflow, because struct blocks the issue that would exceed the total.
- Flush FSM, states IDLE / FLUSH, with a down-counter fcnt:
  - ex_redirect in any state loads fcnt=FLUSH_DEPTH and enters FLUSH next cycle. A redirect during FLUSH restarts the count.
  - flush_o = (state==FLUSH). Each FLUSH cycle decrements fcnt; at fcnt==1 with no new redirect, return to IDLE.
  - Redirect under pipe_freeze is still captured; the count decrements only when pipe_freeze=0.
- Already-issued long ops are older than the redirecting branch and are never squashed, so the scoreboard needs no flush-time correction.
- sb_full_o = (total==MAX_PEND), registered value. pend_total_o = total.
- Reset mid-operation clears all state immediately; in-flight writebacks after reset are ignored only via sb_err_o (the bench must not drive them).

Decomposition:
- rv32i_types gains functions uses_rs1(rv32i_opcode) and uses_rs2(rv32i_opcode), so decode is shared with the forwarding unit. No new package.
- Sub-module hd_flush_ctrl: the flush FSM and counter, parameter FLUSH_DEPTH. Ports: clk, rst_n, ex_redirect, pipe_freeze, flush_o.

Test Plan:
- Load x5 issued, next cycle op_reg rs1=5 -> stall_o=1 until wb_long wb_rd=5; in the wb cycle stall_o=0 and the consumer fires; cnt[5] returns to 0.
- op_imm with rs2 field=5 while x5 pending -> stall_o=0 (rs2 ignored). Same with op_store rs2=5 -> stall_o=1.
- MAX_PEND=4: issue 4 loads to x1..x4, then a 5th load -> sb_full_o=1, stall_o=1; retire x2 in the same cycle -> 5th load fires, total stays 4.
- Two loads to x7 outstanding, first retires -> consumer of x7 still stalls; second retire -> stall drops. Load to x0 -> never tracked, pend_total_o unchanged.
- ex_redirect pulse, FLUSH_DEPTH=2 -> flush_o high exactly 2 cycles, stall_o masked. Second redirect in flush cycle 1 -> flush_o high for 2 further cycles.
- rst_n low while 3 loads are pending and flush is active -> all outputs 0 asynchronously; a retire with no pending count -> sb_err_o=1 and stays set.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rv32i decode types and helpers, used by the hazard and forwarding units.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    // Instruction reads rs1.
    function automatic logic uses_rs1(rv32i_opcode op);
        case (op)
            op_jalr, op_br, op_load, op_store, op_imm, op_reg: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // Instruction reads rs2 (op_imm carries immediate bits in the rs2 field).
    function automatic logic uses_rs2(rv32i_opcode op);
        case (op)
            op_br, op_store, op_reg: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hd_scoreboard_flush_ctrl.sv
// Front-end flush sequencer: holds flush_o for FLUSH_DEPTH unfrozen cycles per redirect.
//
// state | meaning
// IDLE  | no flush in progress
// FLUSH | flush_o high; fcnt counts remaining unfrozen flush cycles
module hd_flush_ctrl #(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ex_redirect,
    input  logic pipe_freeze,
    output logic flush_o
);

    localparam int FW = $clog2(FLUSH_DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    flush_state_e   state_q, state_d;
    logic [FW-1:0]  fcnt_q, fcnt_d;

    // State and down-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state: a redirect always (re)loads the count; frozen cycles do not consume it.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (ex_redirect) begin
            state_d = FLUSH;
            fcnt_d  = FW'(FLUSH_DEPTH);
        end else if (state_q == FLUSH && !pipe_freeze) begin
            if (fcnt_q == FW'(1)) begin
                state_d = IDLE;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - FW'(1);
            end
        end
    end

    assign flush_o = (state_q == FLUSH);

endmodule

// File: rtl/hd_scoreboard.sv
// Per-register pending-count hazard unit for long-latency producers, plus redirect flush.
module hd_scoreboard
    import rv32i_types::*;
#(
    parameter int NREGS       = 32,
    parameter int MAX_PEND    = 4,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  rv32i_opcode                   id_opcode,
    input  logic [4:0]                    id_rs1,
    input  logic [4:0]                    id_rs2,
    input  logic [4:0]                    id_rd,
    input  logic                          id_long_ext,
    input  logic                          pipe_freeze,
    input  logic                          wb_valid,
    input  logic                          wb_long,
    input  logic [4:0]                    wb_rd,
    input  logic                          ex_redirect,
    output logic                          stall_o,
    output logic                          flush_o,
    output logic                          sb_full_o,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_total_o,
    output logic                          sb_err_o
);

    localparam int CW = $clog2(MAX_PEND + 1);

    logic [CW-1:0] cnt_q [NREGS];
    logic [CW-1:0] cnt_d [NREGS];
    logic [CW-1:0] total_q, total_d, total_eff;
    logic          err_q, err_d;

    logic          ret, is_long, busy1, busy2, raw, strc, fire, iss, ret_tot;
    logic [CW-1:0] cnt_rs1, cnt_rs2;

    hd_flush_ctrl #(.FLUSH_DEPTH(FLUSH_DEPTH)) u_flush (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_redirect (ex_redirect),
        .pipe_freeze (pipe_freeze),
        .flush_o     (flush_o)
    );

    assign ret     = wb_valid & wb_long & (wb_rd != 5'd0);
    assign is_long = (id_opcode == op_load) | id_long_ext;
    assign cnt_rs1 = cnt_q[id_rs1];
    assign cnt_rs2 = cnt_q[id_rs2];

    // A same-cycle retire of the last pending producer clears the hazard (regfile writes through).
    assign busy1 = (id_rs1 != 5'd0) & (cnt_rs1 != '0)
                 & ~(ret & (wb_rd == id_rs1) & (cnt_rs1 == CW'(1)));
    assign busy2 = (id_rs2 != 5'd0) & (cnt_rs2 != '0)
                 & ~(ret & (wb_rd == id_rs2) & (cnt_rs2 == CW'(1)));

    assign total_eff = (ret && total_q != '0) ? total_q - CW'(1) : total_q;

    assign raw  = id_valid & ((uses_rs1(id_opcode) & busy1) | (uses_rs2(id_opcode) & busy2));
    assign strc = id_valid & is_long & (id_rd != 5'd0) & (total_eff == CW'(MAX_PEND));

    assign stall_o = (raw | strc) & ~flush_o;
    assign fire    = id_valid & ~stall_o & ~flush_o & ~pipe_freeze;
    assign iss     = fire & is_long & (id_rd != 5'd0);
    assign ret_tot = ret & ((total_q != '0) | iss);

    // Next-state counts: +1 on issue, -1 on retire, a retire against zero flags an error.
    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < NREGS; r++) begin
            if (ret && wb_rd == 5'(r) && cnt_q[r] == '0) begin
                err_d = 1'b1;
            end
            if (iss && id_rd == 5'(r) && !(ret && wb_rd == 5'(r))) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (ret && wb_rd == 5'(r) && !(iss && id_rd == 5'(r))
                         && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
        total_d = total_q;
        if (iss && !ret_tot) begin
            total_d = total_q + CW'(1);
        end else if (!iss && ret_tot) begin
            total_d = total_q - CW'(1);
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    assign sb_full_o    = (total_q == CW'(MAX_PEND));
    assign pend_total_o = total_q;
    assign sb_err_o     = err_q;

endmodule
